dff_pipe: RTL and testbench

//   Parametrised elastic register pipeline: WIDTH-bit data through STAGES flop

---
 rtl/dff_pipe.sv | 119 +++++++++++
 tb/tb_dff_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
// dff_pipe : elastic valid/ready register pipeline with flush and occupancy
// Rev 1.0
// ============================================================================
module dff_pipe #(
  parameter int               WIDTH      = 8,
  parameter int               STAGES     = 3,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          in_valid_i,
  input  logic [WIDTH-1:0]              in_data_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  output logic [WIDTH-1:0]              out_data_o,
  input  logic                          out_ready_i,
  input  logic                          flush_i,
  output logic [$clog2(STAGES+1)-1:0]   count_o
);

  localparam int CW = $clog2(STAGES + 1);

  logic [STAGES-1:0]            w_valid;
  logic [STAGES-1:0][WIDTH-1:0] w_data;
  logic [STAGES-1:0]            w_adv;
  logic                         w_in_xfer;
  logic                         w_out_xfer;
  logic [CW-1:0]                w_pop;
  logic [CW-1:0]                w_count_next;
  logic [CW-1:0]                r_count;

  // A stage may move when it is empty or when the stage after it moves.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !w_valid[STAGES-1] | out_ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = !w_valid[k] | w_adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_vin;
    logic [WIDTH-1:0] w_din;
    logic             r_v;
    logic [WIDTH-1:0] r_d;

    if (k == 0) begin : g_head
      assign w_vin = in_valid_i;
      assign w_din = in_data_i;
    end else begin : g_body
      assign w_vin = w_valid[k-1];
      assign w_din = w_data[k-1];
    end

    // Data only loads behind a valid item; flush clears valids but keeps data.
    always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
        r_v <= 1'b0;
        r_d <= RESET_DATA;
      end else begin
        if (flush_i) begin
          r_v <= 1'b0;
        end else if (w_adv[k]) begin
          r_v <= w_vin;
        end
        if (!flush_i && w_adv[k] && w_vin) begin
          r_d <= w_din;
        end
      end
    end

    assign w_valid[k] = r_v;
    assign w_data[k]  = r_d;
  end

  assign in_ready_o  = reset_i & w_adv[0] & !flush_i;
  assign out_valid_o = w_valid[STAGES-1];
  assign out_data_o  = w_data[STAGES-1];
  assign w_in_xfer   = in_valid_i & in_ready_o;
  assign w_out_xfer  = out_valid_o & out_ready_i;

  always_comb begin
    w_count_next = r_count;
    if (flush_i) begin
      w_count_next = '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count_o = r_count;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_pop = w_pop + CW'(w_valid[k]);
    end
  end

`ifndef SYNTHESIS
  a_count_matches_popcount : assert property (
    @(posedge clock_i) disable iff (!reset_i) r_count == w_pop
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// ============================================================================
// tb_dff_pipe : directed and randomised checks of the elastic pipeline
// Rev 1.0
// ============================================================================
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       flush;
  logic [1:0] count;

  logic        r_in_valid;
  logic [15:0] r_in_data;
  logic        r_out_ready;
  logic        r_flush;
  logic [2:0]  r_ir;
  logic [2:0]  r_ov;
  logic [15:0] r_od [3];
  logic [0:0]  c1;
  logic [1:0]  c3;
  logic [2:0]  c5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .STAGES(3), .RESET_DATA(8'h5A)) u_dut (
    .clock_i(clk), .reset_i(reset_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .flush_i(flush), .count_o(count)
  );

  dff_pipe #(.WIDTH(16), .STAGES(1)) u_r1 (
    .clock_i(clk), .reset_i(reset_n), .in_valid_i(r_in_valid), .in_data_i(r_in_data),
    .in_ready_o(r_ir[0]), .out_valid_o(r_ov[0]), .out_data_o(r_od[0]),
    .out_ready_i(r_out_ready), .flush_i(r_flush), .count_o(c1)
  );

  dff_pipe #(.WIDTH(16), .STAGES(3)) u_r3 (
    .clock_i(clk), .reset_i(reset_n), .in_valid_i(r_in_valid), .in_data_i(r_in_data),
    .in_ready_o(r_ir[1]), .out_valid_o(r_ov[1]), .out_data_o(r_od[1]),
    .out_ready_i(r_out_ready), .flush_i(r_flush), .count_o(c3)
  );

  dff_pipe #(.WIDTH(16), .STAGES(5)) u_r5 (
    .clock_i(clk), .reset_i(reset_n), .in_valid_i(r_in_valid), .in_data_i(r_in_data),
    .in_ready_o(r_ir[2]), .out_valid_o(r_ov[2]), .out_data_o(r_od[2]),
    .out_ready_i(r_out_ready), .flush_i(r_flush), .count_o(c5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL reset_out_data got=%h exp=5a", out_data); end
    reset_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_stream();
    logic       ev;
    logic [7:0] ed;
    int         ec;
    out_ready = 1'b1; flush = 1'b0;
    for (int c = 0; c < 15; c++) begin
      in_valid = (c < 10); in_data = 8'(c + 1);
      #1;
      ev = (c >= 3 && c <= 12);
      ed = 8'(c - 2);
      ec = (c <= 3) ? c : (c <= 10) ? 3 : (c <= 13) ? 13 - c : 0;
      checks++; if (out_valid !== ev) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, out_valid, ev); end
      if (ev) begin
        checks++; if (out_data !== ed) begin errors++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, out_data, ed); end
      end
      checks++; if (count !== 2'(ec)) begin errors++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", c, count, ec); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready cyc=%0d got=%b exp=1", c, in_ready); end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [7:0] vals [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    int  sent = 0;
    int  n = 0;
    bit  ix, ox;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = vals[sent];
      #1;
      checks++; if (in_ready !== (c < 3)) begin errors++; $display("FAIL bp_fill_ready cyc=%0d got=%b exp=%b", c, in_ready, (c < 3)); end
      ix = in_ready;
      tick();
      if (ix) sent++;
    end
    checks++; if (sent != 3) begin errors++; $display("FAIL bp_accepted got=%0d exp=3", sent); end
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL bp_count got=%0d exp=3", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL bp_head got=%b/%h exp=1/a1", out_valid, out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (sent < 4);
      if (sent < 4) in_data = vals[sent];
      #1;
      if (c == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_full_ready got=%b exp=1", in_ready); end
      end
      if (c == 1) begin
        checks++; if (count !== 2'd3) begin errors++; $display("FAIL bp_full_count got=%0d exp=3", count); end
      end
      ix = in_valid & in_ready;
      ox = out_valid & out_ready;
      if (ox) begin
        checks++;
        if (n >= 4) begin errors++; $display("FAIL bp_extra_out got=%h exp=none", out_data); end
        else if (out_data !== vals[n]) begin errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", n, out_data, vals[n]); end
        n++;
      end
      tick();
      if (ix) sent++;
    end
    in_valid = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL bp_out_total got=%0d exp=4", n); end
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0d/%b exp=0/0", count, out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c == 0 || c == 2);
      in_data = (c == 0) ? 8'h11 : 8'h22;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_ready cyc=%0d got=%b exp=1", c, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL bubble_count got=%0d exp=2", count); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL bubble_head got=%b/%h exp=1/11", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_ready_held got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin errors++; $display("FAIL bubble_packed got=%b/%h exp=1/22", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL bubble_drained got=%b/%0d exp=0/0", out_valid, count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 8'(8'hB1 + c);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'hB1) begin errors++; $display("FAIL flush_data_hold got=%h exp=b1", out_data); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hDD; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_empty_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL flush_refused cyc=%0d got=%b/%0d exp=0/0", c, out_valid, count); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] mem [3][8];
    int          head [3];
    int          depth [3];
    int          stg [3] = '{1, 3, 5};
    logic [2:0]  cnt [3];
    bit          ix, ox;
    for (int i = 0; i < 3; i++) begin head[i] = 0; depth[i] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) begin
        reset_n = 1'b0; r_in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (r_ov[i] !== 1'b0 || r_ir[i] !== 1'b0) begin errors++; $display("FAIL rnd_reset dut=%0d got=%b/%b exp=0/0", i, r_ov[i], r_ir[i]); end
          head[i] = 0; depth[i] = 0;
        end
        tick();
        reset_n = 1'b1;
      end
      cnt[0] = {2'b00, c1}; cnt[1] = {1'b0, c3}; cnt[2] = c5;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cnt[i] !== 3'(depth[i])) begin errors++; $display("FAIL rnd_count dut=%0d cyc=%0d got=%0d exp=%0d", i, cyc, cnt[i], depth[i]); end
        checks++;
        if (depth[i] == 0) begin
          if (r_ov[i] !== 1'b0) begin errors++; $display("FAIL rnd_empty_valid dut=%0d cyc=%0d got=%b exp=0", i, cyc, r_ov[i]); end
        end else if (r_ov[i] === 1'b1 && r_od[i] !== mem[i][head[i]]) begin
          errors++; $display("FAIL rnd_data dut=%0d cyc=%0d got=%h exp=%h", i, cyc, r_od[i], mem[i][head[i]]);
        end
      end
      r_in_valid  = 1'($urandom_range(0, 1));
      r_in_data   = 16'($urandom);
      r_out_ready = ($urandom_range(0, 99) < ((cyc < 2500 || cyc >= 7500) ? 30 : 80));
      #1;
      for (int i = 0; i < 3; i++) begin
        if (r_out_ready) begin
          checks++; if (r_ir[i] !== 1'b1) begin errors++; $display("FAIL rnd_ready_pass dut=%0d cyc=%0d got=%b exp=1", i, cyc, r_ir[i]); end
        end else if (depth[i] == stg[i]) begin
          checks++; if (r_ir[i] !== 1'b0) begin errors++; $display("FAIL rnd_ready_full dut=%0d cyc=%0d got=%b exp=0", i, cyc, r_ir[i]); end
        end
        ix = r_in_valid & r_ir[i];
        ox = r_ov[i] & r_out_ready;
        if (ox && depth[i] > 0) begin head[i] = (head[i] + 1) % 8; depth[i]--; end
        if (ix) begin mem[i][(head[i] + depth[i]) % 8] = r_in_data; depth[i]++; end
      end
      tick();
    end
    r_in_valid = 1'b0; r_out_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0;
    r_in_valid = 1'b0; r_in_data = 16'h0000; r_out_ready = 1'b0; r_flush = 1'b0;
    test_reset();
    test_stream();
    test_back_pressure();
    test_bubble();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
